// File: rtl/pipeline_stall_unit_pkg.sv
// ============================================================================
// Module : pipeline_stall_unit_pkg
// Purpose: Shared constants for the pipeline stall/bubble controller:
//          stall-vector bit positions, FSM state encodings and the NOP word
//          that the ID/EX register is loaded with on a bubble.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_stall_unit_pkg;

   // Bit positions inside the per-stage stall vector
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // FSM state encodings
   localparam int         STATE_WIDTH = 2;
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT     = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   // sll $0,$0,0 -- the canonical MIPS NOP
   localparam logic [31:0] NOP = 32'h0000_0000;

   // Stall vector holding the front end (PC, IF, ID) for a load-use hazard
   function automatic logic [5:0] load_use_mask();
      logic [5:0] m;
      m            = '0;
      m[STALL_PC]  = 1'b1;
      m[STALL_IF]  = 1'b1;
      m[STALL_ID]  = 1'b1;
      return m;
   endfunction

   // Stall vector freezing everything except WB, which is allowed to drain
   function automatic logic [5:0] mem_wait_mask();
      logic [5:0] m;
      m            = '1;
      m[STALL_WB]  = 1'b0;
      return m;
   endfunction

endpackage : pipeline_stall_unit_pkg

`default_nettype wire

// File: rtl/pipeline_stall_unit_if.sv
// ============================================================================
// Module : pipeline_stall_unit_if
// Purpose: Bundles the hazard-detection inputs and stall-control outputs of
//          the pipeline stall unit.
// Ports  : master -- pipeline side: drives ID/EX/MEM status, receives stalls
//          slave  -- stall unit: consumes status, drives stall/bubble/timeout
//                    and the stall-cycle counter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_stall_unit_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STAGE_COUNT    = 6,
   parameter int COUNT_WIDTH    = 32
);

   logic                      id_read_enable_1;
   logic                      id_read_enable_2;
   logic [REG_ADDR_WIDTH-1:0] id_read_address_1;
   logic [REG_ADDR_WIDTH-1:0] id_read_address_2;
   logic                      ex_is_load;
   logic [REG_ADDR_WIDTH-1:0] ex_write_address;
   logic                      mem_request;
   logic                      mem_ready;
   logic [STAGE_COUNT-1:0]    stall;
   logic                      bubble;
   logic                      timeout;
   logic [COUNT_WIDTH-1:0]    stall_cycles;

   modport master (
      output id_read_enable_1, id_read_enable_2,
      output id_read_address_1, id_read_address_2,
      output ex_is_load, ex_write_address,
      output mem_request, mem_ready,
      input  stall, bubble, timeout, stall_cycles
   );

   modport slave (
      input  id_read_enable_1, id_read_enable_2,
      input  id_read_address_1, id_read_address_2,
      input  ex_is_load, ex_write_address,
      input  mem_request, mem_ready,
      output stall, bubble, timeout, stall_cycles
   );

endinterface : pipeline_stall_unit_if

`default_nettype wire

// File: rtl/pipeline_stall_unit_hazard_compare.sv
// ============================================================================
// Module : pipeline_stall_unit_hazard_compare
// Purpose: Combinational load-use detector. Flags a hazard when the load in
//          EX writes a register (other than $0) that ID is about to read on
//          either operand.
// Ports  : read_enable_1_i/2_i   ID operand read enables
//          read_address_1_i/2_i  ID operand register indices
//          ex_is_load_i          EX holds a load
//          ex_write_address_i    EX destination register
//          hazard_o              load-use hazard this cycle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_stall_unit_hazard_compare #(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  wire logic                      read_enable_1_i,
   input  wire logic [REG_ADDR_WIDTH-1:0] read_address_1_i,
   input  wire logic                      read_enable_2_i,
   input  wire logic [REG_ADDR_WIDTH-1:0] read_address_2_i,
   input  wire logic                      ex_is_load_i,
   input  wire logic [REG_ADDR_WIDTH-1:0] ex_write_address_i,
   output logic                           hazard_o
);

   logic match_1;
   logic match_2;
   logic dest_valid;

   // $0 is hard-wired to zero, so a load targeting it never produces data
   assign dest_valid = ex_is_load_i & (ex_write_address_i != '0);
   assign match_1    = read_enable_1_i & (read_address_1_i == ex_write_address_i);
   assign match_2    = read_enable_2_i & (read_address_2_i == ex_write_address_i);
   assign hazard_o   = dest_valid & (match_1 | match_2);

endmodule : pipeline_stall_unit_hazard_compare

`default_nettype wire

// File: rtl/pipeline_stall_unit.sv
// ============================================================================
// Module : pipeline_stall_unit
// Purpose: Stall/bubble controller for the 5-stage MIPS pipeline. Handles the
//          single-cycle load-use stall, variable-latency data memory waits,
//          a sticky wait-timeout error and a saturating stall-cycle counter.
// Ports  : clock   rising-edge clock
//          reset   asynchronous, active-high
//          bus     pipeline_stall_unit_if.slave:
//                    in : id_read_enable_1/2, id_read_address_1/2,
//                         ex_is_load, ex_write_address, mem_request, mem_ready
//                    out: stall[STAGE_COUNT], bubble, timeout, stall_cycles
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_stall_unit
   import pipeline_stall_unit_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STAGE_COUNT    = 6,
   parameter int WAIT_WIDTH     = 4,   // must be >= 2
   parameter int COUNT_WIDTH    = 32
) (
   input  wire logic            clock,
   input  wire logic            reset,
   pipeline_stall_unit_if.slave bus
);

   // Number of consecutive wait cycles after which the access is declared dead
   localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = '1;

   logic [STATE_WIDTH-1:0] state_q;
   logic [STATE_WIDTH-1:0] state_d;
   logic [WAIT_WIDTH-1:0]  wait_cnt_q;
   logic [WAIT_WIDTH-1:0]  wait_cnt_d;
   logic                   timeout_q;
   logic                   timeout_d;
   logic [COUNT_WIDTH-1:0] stall_cnt_q;
   logic [COUNT_WIDTH-1:0] stall_cnt_d;

   logic                   hazard;
   logic                   mem_wait;
   logic [STAGE_COUNT-1:0] stall_vec;
   logic                   bubble;

   // ------------------------------------------------------------------------
   // Load-use comparator
   // ------------------------------------------------------------------------
   pipeline_stall_unit_hazard_compare #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_hazard_compare (
      .read_enable_1_i    (bus.id_read_enable_1),
      .read_address_1_i   (bus.id_read_address_1),
      .read_enable_2_i    (bus.id_read_enable_2),
      .read_address_2_i   (bus.id_read_address_2),
      .ex_is_load_i       (bus.ex_is_load),
      .ex_write_address_i (bus.ex_write_address),
      .hazard_o           (hazard)
   );

   // An access is outstanding and not completing this cycle
   assign mem_wait = bus.mem_request & ~bus.mem_ready;

   // ------------------------------------------------------------------------
   // Stall vector / bubble. Purely combinational so the cycle mem_ready
   // rises already releases the pipeline. Gated by reset so the outputs
   // collapse to zero the instant reset is asserted.
   // ------------------------------------------------------------------------
   always_comb begin
      stall_vec = '0;
      bubble    = 1'b0;
      if (reset) begin
         stall_vec = '0;
      end else if (state_q == ST_ERROR) begin
         stall_vec = '1;
      end else if (mem_wait) begin
         // Memory wait wins over load-use; no bubble since ID/EX is frozen
         stall_vec = STAGE_COUNT'(mem_wait_mask());
      end else if (hazard) begin
         stall_vec = STAGE_COUNT'(load_use_mask());
         bubble    = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Memory-wait FSM and wait counter. The counter tracks how many
   // consecutive cycles the current access has been waiting.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_wait) begin
               state_d    = ST_WAIT;
               wait_cnt_d = WAIT_WIDTH'(1);
            end
         end
         ST_WAIT: begin
            if (mem_wait) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (wait_cnt_q == WAIT_LIMIT - 1'b1) begin
                  state_d   = ST_ERROR;
                  timeout_d = 1'b1;
               end
            end else begin
               // Completed (mem_ready) or abandoned (request dropped)
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Saturating count of cycles with any stall bit set
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((|stall_vec) && (stall_cnt_q != {COUNT_WIDTH{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall        = stall_vec;
   assign bus.bubble       = bubble;
   assign bus.timeout      = timeout_q;
   assign bus.stall_cycles = stall_cnt_q;

endmodule : pipeline_stall_unit

`default_nettype wire

// File: tb/tb_pipeline_stall_unit.sv
// ============================================================================
// Module : tb_pipeline_stall_unit
// Purpose: Scoreboard bench for pipeline_stall_unit. A driver issues one
//          cycle of inputs at a time, a reference model computes the expected
//          outputs and queues them; a monitor pops and compares on the
//          falling edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_unit;

   localparam int CW      = 8;               // small counter so saturation is reachable
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int WAIT_TO = 15;              // 2**WAIT_WIDTH-1

   typedef struct packed {
      logic [5:0]    stall;
      logic          bubble;
      logic          timeout;
      logic [CW-1:0] cnt;
      logic [15:0]   tag;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   pipeline_stall_unit_if #(.REG_ADDR_WIDTH(5), .STAGE_COUNT(6), .COUNT_WIDTH(CW)) bus ();

   pipeline_stall_unit #(
      .REG_ADDR_WIDTH (5),
      .STAGE_COUNT    (6),
      .WAIT_WIDTH     (4),
      .COUNT_WIDTH    (CW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state: sticky error flag, consecutive wait cycles,
   // running stall-cycle count.
   bit   m_err   = 1'b0;
   int   m_waits = 0;
   int   m_cnt   = 0;

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s tag=%0d actual=%h required=%h", name, tag, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle once an expectation is queued
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",        int'(e.tag), 32'(bus.stall),        32'(e.stall));
            chk("bubble",       int'(e.tag), 32'(bus.bubble),       32'(e.bubble));
            chk("timeout",      int'(e.tag), 32'(bus.timeout),      32'(e.timeout));
            chk("stall_cycles", int'(e.tag), 32'(bus.stall_cycles), 32'(e.cnt));
         end
      end
   end

   // One clock cycle of stimulus plus the model's prediction for that cycle
   task automatic cyc(input logic rst, input logic ld, input logic [4:0] wa,
                      input logic re1, input logic [4:0] ra1,
                      input logic re2, input logic [4:0] ra2,
                      input logic req, input logic rdy, input int tag);
      exp_t e;
      bit   haz;
      bit   mw;
      @(posedge clock);
      #1;
      reset                 = rst;
      bus.ex_is_load        = ld;
      bus.ex_write_address  = wa;
      bus.id_read_enable_1  = re1;
      bus.id_read_address_1 = ra1;
      bus.id_read_enable_2  = re2;
      bus.id_read_address_2 = ra2;
      bus.mem_request       = req;
      bus.mem_ready         = rdy;

      e        = '0;
      e.tag    = 16'(tag);
      if (rst) begin
         m_err   = 1'b0;
         m_waits = 0;
         m_cnt   = 0;
      end else begin
         haz = ld && (wa != 0) && ((re1 && ra1 == wa) || (re2 && ra2 == wa));
         mw  = req && !rdy;
         if (m_err)    e.stall = 6'b111111;
         else if (mw)  e.stall = 6'b011111;
         else if (haz) begin
            e.stall  = 6'b000111;
            e.bubble = 1'b1;
         end
         e.timeout = m_err;
         e.cnt     = CW'(m_cnt);
         if (e.stall != 0 && m_cnt < CNT_MAX) m_cnt++;
         if (!m_err) begin
            if (mw) begin
               m_waits++;
               if (m_waits >= WAIT_TO) m_err = 1'b1;
            end else begin
               m_waits = 0;
            end
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input int tag);
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, tag);
   endtask

   task automatic do_reset(input int tag);
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, tag);
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      bus.ex_is_load        = 1'b0;
      bus.ex_write_address  = '0;
      bus.id_read_enable_1  = 1'b0;
      bus.id_read_address_1 = '0;
      bus.id_read_enable_2  = 1'b0;
      bus.id_read_address_2 = '0;
      bus.mem_request       = 1'b0;
      bus.mem_ready         = 1'b0;

      do_reset(1);
      idle(2);

      // lw $1 in EX, addu $2,$1,$1 in ID: one stall cycle then bubble in EX
      cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 10);
      cyc(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 11);
      idle(12);

      // addu $2,$1,$0: hazard through operand 1 only
      cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 20);
      // load writing $0 read by ID: never a hazard
      cyc(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 21);
      // operand 2 match with operand 1 disabled
      cyc(1'b0, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 22);
      idle(23);

      // Three wait cycles, then ready
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 30);
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 31);
      // Zero-latency access
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32);
      idle(33);

      // Load-use coincident with a memory wait: memory stall first
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 40);
      cyc(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 41);
      idle(42);

      // Request dropped mid-wait: back to idle without error
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 50);
      idle(51);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 52);
      idle(53);

      // Timeout, then a long sticky error phase that saturates the counter
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 60);
      cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 61);
      for (int i = 0; i < 260; i++) idle(62);
      do_reset(63);

      // Reset in the middle of a wait, then a fresh load-use pair
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 70);
      cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 71);
      cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 72);
      cyc(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 73);

      // Randomized traffic with small register indices to provoke matches
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 49) == 0),
             1'($urandom_range(0, 1)),  5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),  5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),  5'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             1000 + i);
      end

      repeat (3) @(posedge clock);
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_pipeline_stall_unit

`default_nettype wire
